// File: rtl/bet_pkg.sv
// Shared constants and types for the roulette bet-entry controller.
// Opcode and PS/2 scan-code constants plus the entry FSM state encoding.
package bet_pkg;

    localparam logic [5:0] OP_MAX_BET = 6'd49;
    localparam logic [5:0] OP_SPIN    = 6'd62;
    localparam logic [5:0] OP_INVALID = 6'd63;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_ESC   = 8'h76;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_BRK,
        ST_LOOKUP,
        ST_SPIN_WAIT,
        ST_DRAIN
    } state_e;

    function automatic logic is_bet_op(input logic [5:0] op);
        return op <= OP_MAX_BET;
    endfunction

endpackage

// File: rtl/bet_table.sv
// Bet table: MAX_BETS slots of {opcode, chips}, match/allocate/increment/clear,
// running committed-chip total and an indexed read port used while draining.
module bet_table
    import bet_pkg::*;
#(
    parameter int MAX_BETS = 8,
    parameter int CHIP_W   = 8,
    parameter int CREDIT_W = 16,
    parameter int CNT_W    = $clog2(MAX_BETS + 1),
    parameter int IDX_W    = $clog2(MAX_BETS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                add_en,
    input  logic [5:0]          add_op,
    input  logic                clr,
    input  logic [CREDIT_W-1:0] credit,
    output logic                add_ok,
    output logic [CNT_W-1:0]    bet_count,
    output logic [CREDIT_W-1:0] committed,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [5:0]          rd_opcode,
    output logic [CHIP_W-1:0]   rd_chips
);

    logic [MAX_BETS-1:0]             valid_q, valid_d;
    logic [MAX_BETS-1:0][5:0]        op_q, op_d;
    logic [MAX_BETS-1:0][CHIP_W-1:0] chips_q, chips_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [CREDIT_W-1:0]             committed_q, committed_d;

    logic             hit, free;
    logic [IDX_W-1:0] hit_idx, free_idx;
    logic             credit_ok;

    // Slots fill from index 0 and are only ever cleared all at once, so
    // occupied slots are always contiguous starting at 0.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < MAX_BETS; i++) begin
            if (valid_q[i] && op_q[i] == add_op && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i] && !free) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // >= rather than == so a credit drop below the committed total blocks adds.
    assign credit_ok = committed_q < credit;
    assign add_ok    = credit_ok && (hit ? (chips_q[hit_idx] != '1) : free);

    always_comb begin
        valid_d     = valid_q;
        op_d        = op_q;
        chips_d     = chips_q;
        count_d     = count_q;
        committed_d = committed_q;
        if (clr) begin
            valid_d     = '0;
            op_d        = '0;
            chips_d     = '0;
            count_d     = '0;
            committed_d = '0;
        end else if (add_en && add_ok) begin
            committed_d = committed_q + CREDIT_W'(1);
            if (hit) begin
                chips_d[hit_idx] = chips_q[hit_idx] + CHIP_W'(1);
            end else begin
                valid_d[free_idx] = 1'b1;
                op_d[free_idx]    = add_op;
                chips_d[free_idx] = CHIP_W'(1);
                count_d           = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            op_q        <= '0;
            chips_q     <= '0;
            count_q     <= '0;
            committed_q <= '0;
        end else begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            chips_q     <= chips_d;
            count_q     <= count_d;
            committed_q <= committed_d;
        end
    end

    assign bet_count = count_q;
    assign committed = committed_q;
    assign rd_opcode = op_q[rd_idx];
    assign rd_chips  = chips_q[rd_idx];

endmodule

// File: rtl/bet_entry_ctrl.sv
// PS/2 make-code sequencer that builds a roulette bet table and drains it on SPIN.
// Optional feature: define BET_CLEAR_KEY_EN to make ESC (8'h76) clear the table.
module bet_entry_ctrl
    import bet_pkg::*;
#(
    parameter int MAX_BETS = 8,
    parameter int CHIP_W   = 8,
    parameter int CREDIT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  ps2_data,
    input  logic                        ps2_valid,
    output logic [7:0]                  key_code,
    input  logic [5:0]                  dec_opcode,
    input  logic [CREDIT_W-1:0]         credit,
    output logic [CREDIT_W-1:0]         chips_committed,
    output logic [$clog2(MAX_BETS+1)-1:0] bet_count,
    output logic                        bet_accept,
    output logic                        bet_reject,
    output logic                        spin_req,
    input  logic                        spin_ack,
    output logic                        bet_valid,
    input  logic                        bet_ready,
    output logic [5:0]                  bet_opcode_out,
    output logic [CHIP_W-1:0]           bet_chips_out,
    output logic                        busy
);

    localparam int CNT_W = $clog2(MAX_BETS + 1);
    localparam int IDX_W = $clog2(MAX_BETS);

    state_e           state_q, state_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             accept_q, accept_d;
    logic             reject_q, reject_d;
    logic [IDX_W-1:0] drain_idx_q, drain_idx_d;

    logic             add_en, add_ok, tbl_clr;
    logic [5:0]       rd_opcode;
    logic [CHIP_W-1:0] rd_chips;
    logic             drain_last, drain_fire;

    bet_table #(
        .MAX_BETS (MAX_BETS),
        .CHIP_W   (CHIP_W),
        .CREDIT_W (CREDIT_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .add_en    (add_en),
        .add_op    (dec_opcode),
        .clr       (tbl_clr),
        .credit    (credit),
        .add_ok    (add_ok),
        .bet_count (bet_count),
        .committed (chips_committed),
        .rd_idx    (drain_idx_q),
        .rd_opcode (rd_opcode),
        .rd_chips  (rd_chips)
    );

    assign drain_fire = (state_q == ST_DRAIN) && bet_ready;
    assign drain_last = CNT_W'(drain_idx_q) == (bet_count - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ENTRY;
            key_code_q  <= 8'h00;
            accept_q    <= 1'b0;
            reject_q    <= 1'b0;
            drain_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            accept_q    <= accept_d;
            reject_q    <= reject_d;
            drain_idx_q <= drain_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        drain_idx_d = drain_idx_q;
        case (state_q)
            ST_ENTRY: begin
                if (ps2_valid) begin
                    if (ps2_data == PS2_BREAK) begin
                        state_d = ST_BRK;
                    end else if (ps2_data != PS2_EXT) begin
                        key_code_d = ps2_data;
                        state_d    = ST_LOOKUP;
                    end
                end
            end
            ST_BRK: begin
                if (ps2_valid) state_d = ST_ENTRY;
            end
            ST_LOOKUP: begin
                state_d = ST_ENTRY;
`ifdef BET_CLEAR_KEY_EN
                if (key_code_q != PS2_ESC && dec_opcode == OP_SPIN && bet_count != '0)
                    state_d = ST_SPIN_WAIT;
`else
                if (dec_opcode == OP_SPIN && bet_count != '0)
                    state_d = ST_SPIN_WAIT;
`endif
            end
            ST_SPIN_WAIT: begin
                if (spin_ack) begin
                    state_d     = ST_DRAIN;
                    drain_idx_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_fire) begin
                    if (drain_last) begin
                        state_d     = ST_ENTRY;
                        drain_idx_d = '0;
                    end else begin
                        drain_idx_d = drain_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    // Table actions and registered accept/reject pulses.
    always_comb begin
        add_en   = 1'b0;
        tbl_clr  = 1'b0;
        accept_d = 1'b0;
        reject_d = 1'b0;
        if (state_q == ST_LOOKUP) begin
`ifdef BET_CLEAR_KEY_EN
            if (key_code_q == PS2_ESC) begin
                tbl_clr  = 1'b1;
                accept_d = 1'b1;
            end else
`endif
            begin
                if (is_bet_op(dec_opcode)) begin
                    add_en   = 1'b1;
                    accept_d = add_ok;
                    reject_d = !add_ok;
                end else if (dec_opcode == OP_SPIN) begin
                    accept_d = bet_count != '0;
                    reject_d = bet_count == '0;
                end else begin
                    reject_d = 1'b1;
                end
            end
        end
        if (drain_fire && drain_last) tbl_clr = 1'b1;
    end

    assign key_code       = key_code_q;
    assign bet_accept     = accept_q;
    assign bet_reject     = reject_q;
    assign spin_req       = state_q == ST_SPIN_WAIT;
    assign busy           = (state_q == ST_SPIN_WAIT) || (state_q == ST_DRAIN);
    assign bet_valid      = state_q == ST_DRAIN;
    assign bet_opcode_out = bet_valid ? rd_opcode : 6'd0;
    assign bet_chips_out  = bet_valid ? rd_chips : '0;

endmodule

// File: tb/tb_bet_entry_ctrl.sv
// Directed bench for bet_entry_ctrl: vector table for bet entry plus
// hand-written sequences for break/extended prefixes, saturation, spin/drain and reset.
module tb_bet_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ps2_data = 8'h00;
    logic        ps2_valid = 1'b0;
    logic [7:0]  key_code;
    logic [5:0]  dec_opcode;
    logic [15:0] credit = 16'd100;
    logic [15:0] chips_committed;
    logic [3:0]  bet_count;
    logic        bet_accept, bet_reject, spin_req, bet_valid, busy;
    logic        spin_ack = 1'b0;
    logic        bet_ready = 1'b0;
    logic [5:0]  bet_opcode_out;
    logic [7:0]  bet_chips_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bet_entry_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .key_code(key_code), .dec_opcode(dec_opcode), .credit(credit),
        .chips_committed(chips_committed), .bet_count(bet_count),
        .bet_accept(bet_accept), .bet_reject(bet_reject), .spin_req(spin_req),
        .spin_ack(spin_ack), .bet_valid(bet_valid), .bet_ready(bet_ready),
        .bet_opcode_out(bet_opcode_out), .bet_chips_out(bet_chips_out), .busy(busy)
    );

    // Scan-code-to-opcode decoder model.
    always_comb begin
        case (key_code)
            8'h0E: dec_opcode = 6'd0;
            8'h1E: dec_opcode = 6'd1;
            8'h26: dec_opcode = 6'd2;
            8'h16: dec_opcode = 6'd3;
            8'h25: dec_opcode = 6'd4;
            8'h2E: dec_opcode = 6'd5;
            8'h36: dec_opcode = 6'd6;
            8'h3D: dec_opcode = 6'd7;
            8'h3E: dec_opcode = 6'd8;
            8'h46: dec_opcode = 6'd9;
            8'h1F: dec_opcode = 6'd37;
            8'h1C: dec_opcode = 6'd38;
            8'h14: dec_opcode = 6'd39;
            8'h1A: dec_opcode = 6'd55;
            8'h29: dec_opcode = 6'd62;
            default: dec_opcode = 6'd63;
        endcase
    end

    typedef struct {
        logic        rst;
        logic [7:0]  pre;
        logic [7:0]  key;
        logic [15:0] credit;
        logic        acc;
        logic        rej;
        logic [3:0]  cnt;
        logic [15:0] comm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [7:0] p, logic [7:0] k, logic [15:0] c,
                                logic a, logic j, logic [3:0] n, logic [15:0] m);
        vec_t v;
        v.rst = r; v.pre = p; v.key = k; v.credit = c;
        v.acc = a; v.rej = j; v.cnt = n; v.comm = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ps2_valid = 1'b0; spin_ack = 1'b0; bet_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ps2_data = b; ps2_valid = 1'b1;
        @(negedge clk);
        ps2_valid = 1'b0; ps2_data = 8'h00;
    endtask

    // Make code: key_code after 1 clk, pulse sampled just after the 2nd edge.
    task automatic press(input string name, input logic [7:0] k, input logic a, input logic j);
        send_byte(k);
        chk({name, "_key"}, key_code, k);
        @(posedge clk); #1;
        chk({name, "_acc"}, bet_accept, a);
        chk({name, "_rej"}, bet_reject, j);
    endtask

    task automatic quiet_press(input logic [7:0] k);
        send_byte(k);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] keys9 [9];
        int acc_n;
        keys9 = '{8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

        // Section 1: repeated key against a credit of 2
        vecs.push_back(mk(1, 8'h00, 8'h1F, 16'd2, 1, 0, 4'd1, 16'd1));
        vecs.push_back(mk(0, 8'h00, 8'h1F, 16'd2, 1, 0, 4'd1, 16'd2));
        vecs.push_back(mk(0, 8'h00, 8'h1F, 16'd2, 0, 1, 4'd1, 16'd2));
        // Section 2: fill the table, 9th distinct key refused, existing key still adds
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(i == 0, 8'h00, keys9[i], 16'd100, 1, 0, 4'(i + 1), 16'(i + 1)));
        vecs.push_back(mk(0, 8'h00, keys9[8], 16'd100, 0, 1, 4'd8, 16'd8));
        vecs.push_back(mk(0, 8'h00, 8'h0E, 16'd100, 1, 0, 4'd8, 16'd9));
        // Section 3: spin on empty, extended prefix, unmapped/reserved codes, credit drop
        vecs.push_back(mk(1, 8'h00, 8'h29, 16'd100, 0, 1, 4'd0, 16'd0));
        vecs.push_back(mk(0, 8'hE0, 8'h14, 16'd100, 1, 0, 4'd1, 16'd1));
        vecs.push_back(mk(0, 8'h00, 8'h7E, 16'd100, 0, 1, 4'd1, 16'd1));
        vecs.push_back(mk(0, 8'h00, 8'h1A, 16'd100, 0, 1, 4'd1, 16'd1));
        vecs.push_back(mk(0, 8'h00, 8'h1C, 16'd0,   0, 1, 4'd1, 16'd1));

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_key", key_code, 8'h00);
        chk("rst_cnt", bet_count, 4'd0);
        chk("rst_comm", chips_committed, 16'd0);
        chk("rst_spin", spin_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", bet_valid, 1'b0);
        chk("rst_pulses", {bet_accept, bet_reject}, 2'b00);

        // Break code then release byte: nothing happens
        send_byte(8'hF0);
        send_byte(8'h16);
        acc_n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bet_accept || bet_reject) acc_n++;
        end
        chk("brk_key", key_code, 8'h00);
        chk("brk_pulses", acc_n, 0);
        chk("brk_cnt", bet_count, 4'd0);
        press("first", 8'h16, 1, 0);
        chk("first_cnt", bet_count, 4'd1);
        chk("first_comm", chips_committed, 16'd1);

        // spin_ack outside SPIN_WAIT is ignored
        @(negedge clk); spin_ack = 1'b1;
        @(negedge clk); spin_ack = 1'b0;
        chk("ack_idle_busy", busy, 1'b0);
        chk("ack_idle_valid", bet_valid, 1'b0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            credit = vecs[i].credit;
            if (vecs[i].pre != 8'h00) send_byte(vecs[i].pre);
            press($sformatf("vec%0d", i), vecs[i].key, vecs[i].acc, vecs[i].rej);
            chk($sformatf("vec%0d_cnt", i), bet_count, vecs[i].cnt);
            chk($sformatf("vec%0d_comm", i), chips_committed, vecs[i].comm);
        end

        // Chip saturation at 255 on one slot
        do_reset();
        credit = 16'd300;
        acc_n = 0;
        for (int i = 0; i < 255; i++) begin
            quiet_press(8'h0E);
            if (bet_accept && !bet_reject) acc_n++;
        end
        chk("sat_accepts", acc_n, 255);
        press("sat_last", 8'h0E, 0, 1);
        chk("sat_comm", chips_committed, 16'd255);

        // Spin and drain with back-pressure
        do_reset();
        credit = 16'd100;
        press("d_b0", 8'h0E, 1, 0);
        press("d_b1", 8'h16, 1, 0);
        press("d_b2", 8'h16, 1, 0);
        press("d_spin", 8'h29, 1, 0);
        chk("d_spin_req", spin_req, 1'b1);
        chk("d_busy", busy, 1'b1);
        send_byte(8'h1E);
        @(posedge clk); #1;
        chk("d_locked_pulses", {bet_accept, bet_reject}, 2'b00);
        chk("d_locked_cnt", bet_count, 4'd2);
        chk("d_locked_key", key_code, 8'h29);
        @(negedge clk); spin_ack = 1'b1;
        @(negedge clk); spin_ack = 1'b0;
        chk("d_spin_drop", spin_req, 1'b0);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("d0_valid_s%0d", s), bet_valid, 1'b1);
            chk($sformatf("d0_op_s%0d", s), bet_opcode_out, 6'd0);
            chk($sformatf("d0_chips_s%0d", s), bet_chips_out, 8'd1);
            @(negedge clk);
        end
        bet_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); bet_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("d1_valid_s%0d", s), bet_valid, 1'b1);
            chk($sformatf("d1_op_s%0d", s), bet_opcode_out, 6'd3);
            chk($sformatf("d1_chips_s%0d", s), bet_chips_out, 8'd2);
            @(negedge clk);
        end
        bet_ready = 1'b1;
        @(posedge clk); #1;
        chk("d_end_valid", bet_valid, 1'b0);
        chk("d_end_cnt", bet_count, 4'd0);
        chk("d_end_comm", chips_committed, 16'd0);
        chk("d_end_busy", busy, 1'b0);
        @(negedge clk); bet_ready = 1'b0;
        press("d_after", 8'h16, 1, 0);
        chk("d_after_cnt", bet_count, 4'd1);

        // Reset asserted mid-drain
        do_reset();
        press("r_b0", 8'h0E, 1, 0);
        press("r_b1", 8'h16, 1, 0);
        press("r_spin", 8'h29, 1, 0);
        @(negedge clk); spin_ack = 1'b1;
        @(negedge clk); spin_ack = 1'b0;
        chk("r_in_drain", bet_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_valid", bet_valid, 1'b0);
        chk("r_busy", busy, 1'b0);
        chk("r_spin_req", spin_req, 1'b0);
        chk("r_cnt", bet_count, 4'd0);
        chk("r_comm", chips_committed, 16'd0);
        chk("r_key", key_code, 8'h00);
        chk("r_op", {bet_opcode_out, bet_chips_out}, 14'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ESC key
        do_reset();
        press("e_b0", 8'h0E, 1, 0);
        press("e_b1", 8'h16, 1, 0);
        press("e_b2", 8'h1E, 1, 0);
`ifdef BET_CLEAR_KEY_EN
        press("esc", 8'h76, 1, 0);
        chk("esc_cnt", bet_count, 4'd0);
        chk("esc_comm", chips_committed, 16'd0);
`else
        press("esc", 8'h76, 0, 1);
        chk("esc_cnt", bet_count, 4'd3);
        chk("esc_comm", chips_committed, 16'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
